// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell walks two WIDTH-bit operands LSB first.
// Optional subtract mode (sub port, b inverted, carry-in forced to 1) under SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  b_load;
    logic              cin_load;
    logic              fa_sum, fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1; cout=1 means no borrow.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = cin_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cout_d  = fa_carry;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: expected {cout,sum} queued at issue, popped on done.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    logic [W:0]   exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic, truncated to WIDTH+1 bits.
    function automatic logic [W:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
        int unsigned t;
        if (rsub) t = int'(ra) - int'(rb) + (1 << W);
        else      t = int'(ra) + int'(rb) + int'(rcin);
        return t[W:0];
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_and_done_exclusive", 32'(busy & done), 32'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    chk("result_cout_sum", 32'({cout, sum}), 32'(e));
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                          input logic osub, input int restart_at, input int abort_at);
        @(posedge clk); #1;
        a = oa; b = ob; cin = ocin; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub = osub;
`endif
        exp_q.push_back(ref_model(oa, ob, ocin, osub));
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= int'(W); k++) begin
            @(negedge clk);
            if (k == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_sum", 32'(sum), 32'd0);
                chk("abort_cout", 32'(cout), 32'd0);
                void'(exp_q.pop_back());
                for (int j = 0; j < 12; j++) begin
                    @(negedge clk);
                    chk("abort_no_done", 32'(done), 32'd0);
                end
                return;
            end
            chk("busy_timing", 32'(busy), 32'(k < int'(W)));
            chk("done_timing", 32'(done), 32'(k == int'(W)));
            if (k < int'(W)) begin
                @(posedge clk); #1;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
                start = (k == restart_at);
                if (k == restart_at) begin
                    a = '0; b = '0;
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after_done_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("no_queued_start", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_no_done", 32'(done), 32'd0);
        end

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, -1, -1);
        run_op(8'hFF, 8'h01, 1'b1, 1'b0, -1, -1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, -1, -1);
        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 2, -1);
        run_op(8'h5A, 8'hC3, 1'b1, 1'b0, -1, 4);
        run_op(8'h10, 8'h20, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        chk("hold_sum_in_idle", 32'(sum), 32'h30);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, -1, -1);
        end

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h20, 8'h05, 1'b0, 1'b1, -1, -1);
        run_op(8'h05, 8'h20, 1'b1, 1'b1, -1, -1);
        for (int i = 0; i < 10; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), -1, -1);
        end
`endif

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
